fog_param_cmd_rx: RTL and testbench
===================================

Name: fog_param_cmd_rx

Overview:
Upstream configuration stage for the FOG modulation/demodulation core. It consumes a byte stream from the FPGA_RX UART receiver and parses fixed 8-byte command frames. Valid frames write the seven loop parameters (freq_cnt, amp_H, amp_L, polarity, wait_cnt, err_offset, avg_sel) into registers that drive the FOG core's var_* inputs directly, replacing the tie-off constants. It also reports frame acknowledgement and error status.

Parameters:
TIMEOUT_CYC, 100000, max idle cycles between bytes inside a frame before abort (1 ms at 100 MHz)
AVG_SEL_MAX, 14, upper clamp for avg_sel
HDR0, 8'hAB, first header byte
HDR1, 8'hBA, second header byte

Ports:
pll_clk_cpu_int  in  1  CPU-domain clock
RST_EXT_N  in  1  asynchronous active-low reset
i_rx_data  in  8  received byte
i_rx_valid  in  1  one-cycle strobe, i_rx_data valid
o_freq_cnt  out  32  to var_freq_cnt
o_amp_H  out  32  to var_amp_H
o_amp_L  out  32  to var_amp_L
o_polarity  out  1  to var_polarity
o_wait_cnt  out  32  to var_wait_cnt
o_err_offset  out  32  to var_err_offset
o_avg_sel  out  32  to var_avg_sel
o_cfg_update  out  1  one-cycle pulse when any parameter register is written
o_cmd_addr  out  8  address of the last committed command
o_err_pulse  out  1  one-cycle pulse on checksum, address or timeout error
o_err_cnt  out  8  saturating error counter

Behaviour:
- Reset is RST_EXT_N, asynchronous and active-low. Clock is pll_clk_cpu_int. All state is in this one domain.
- Reset values: freq_cnt=1000, amp_H=5000, amp_L=5000, polarity=0, wait_cnt=50, err_offset=0, avg_sel=10. o_cfg_update=0, o_err_pulse=0, o_err_cnt=0, o_cmd_addr=0. The FSM resets to S_HDR0.
- Frame format: HDR0, HDR1, ADDR, D3, D2, D1, D0 (big-endian), CHK. CHK = ADDR ^ D3 ^ D2 ^ D1 ^ D0.
- FSM states: S_HDR0, S_HDR1, S_ADDR, S_DATA (2-bit byte index 0..3), S_CHK, S_COMMIT.
  - S_HDR0: on a valid byte equal to HDR0, go to S_HDR1. Any other byte is ignored silently.
  - S_HDR1: byte equal to HDR1 goes to S_ADDR. Byte equal to HDR0 stays in S_HDR1 (resync). Any other byte goes to S_HDR0 with no error.
  - S_ADDR: latch the address and go to S_DATA with index 0.
  - S_DATA: shift the byte into the 32-bit data register. After index 3, go to S_CHK.
  - S_CHK: on checksum match with address 0x00..0x06, go to S_COMMIT. On mismatch or address above 0x06, pulse o_err_pulse, increment o_err_cnt, and go to S_HDR0.
  - S_COMMIT: lasts one cycle. Writes the addressed register, pulses o_cfg_update, updates o_cmd_addr, then returns to S_HDR0. A valid byte arriving in this cycle is evaluated exactly as in S_HDR0.
- Latency: the CHK byte strobe in cycle N gives the register value and o_cfg_update in cycle N+2 (registered S_COMMIT outputs).
- Register map:
  - 0x00 freq_cnt
  - 0x01 amp_H
  - 0x02 amp_L
  - 0x03 polarity = D0[0]; other bits ignored
  - 0x04 wait_cnt
  - 0x05 err_offset
  - 0x06 avg_sel, clamped to AVG_SEL_MAX when the written value exceeds it
- Timeout: an idle counter runs in every state except S_HDR0 and S_COMMIT, and clears on each valid byte. When it reaches TIMEOUT_CYC, the frame aborts to S_HDR0, o_err_pulse fires and o_err_cnt increments. The partial frame writes nothing.
- o_err_cnt saturates at 255.
- Simultaneous timeout and valid byte: the byte wins and the counter clears.
- Reset mid-frame: the FSM and all registers return to their reset values immediately.

Decomposition:
- Package fog_cfg_pkg holds:
  - the FSM state enum
  - the address localparams ADDR_FREQ..ADDR_AVG (0x00..0x06)
  - the default-value constants, shared with the top level
  - the AVG_SEL_MAX default
- No sub-module; a single FSM with a datapath is natural.

Test Plan:
- After reset, outputs equal 1000/5000/5000/0/50/0/10 and o_err_cnt=0.
- Frame AB BA 00 00 00 07 D0 D7 -> o_freq_cnt=2000 two cycles after CHK, one o_cfg_update pulse, o_cmd_addr=0x00.
- Frame AB BA 06 00 00 00 1F 19 (avg_sel=31) -> o_avg_sel=14.
- Frame with CHK corrupted (AB BA 01 00 00 13 88 00) -> o_amp_H stays 5000, o_err_pulse once, o_err_cnt=1.
- AB BA 02 00, then idle TIMEOUT_CYC cycles -> o_err_cnt increments. A following valid amp_L frame with 0x00000064 (CHK 0x66) -> o_amp_L=100.
- Noise bytes 12 AB AB BA 03 00 00 00 01 02, with the next frame's AB sent in the COMMIT cycle -> o_polarity=1, and the next frame is parsed correctly.

Source files
------------

// File: rtl/fog_cfg_pkg.sv
// Shared types and constants for the FOG parameter command receiver:
// FSM states, register addresses, reset defaults and the register-write helper.
package fog_cfg_pkg;

  typedef enum logic [2:0] {
    S_HDR0,
    S_HDR1,
    S_ADDR,
    S_DATA,
    S_CHK,
    S_COMMIT
  } state_e;

  localparam logic [7:0] ADDR_FREQ    = 8'h00;
  localparam logic [7:0] ADDR_AMP_H   = 8'h01;
  localparam logic [7:0] ADDR_AMP_L   = 8'h02;
  localparam logic [7:0] ADDR_POL     = 8'h03;
  localparam logic [7:0] ADDR_WAIT    = 8'h04;
  localparam logic [7:0] ADDR_ERR_OFS = 8'h05;
  localparam logic [7:0] ADDR_AVG     = 8'h06;

  localparam logic [31:0] DEF_FREQ_CNT   = 32'd1000;
  localparam logic [31:0] DEF_AMP_H      = 32'd5000;
  localparam logic [31:0] DEF_AMP_L      = 32'd5000;
  localparam logic        DEF_POLARITY   = 1'b0;
  localparam logic [31:0] DEF_WAIT_CNT   = 32'd50;
  localparam logic [31:0] DEF_ERR_OFFSET = 32'd0;
  localparam logic [31:0] DEF_AVG_SEL    = 32'd10;

  localparam logic [31:0] AVG_SEL_MAX_DEF = 32'd14;

  typedef struct packed {
    logic [31:0] freq_cnt;
    logic [31:0] amp_h;
    logic [31:0] amp_l;
    logic        polarity;
    logic [31:0] wait_cnt;
    logic [31:0] err_offset;
    logic [31:0] avg_sel;
  } cfg_t;

  localparam cfg_t CFG_RESET = '{
    freq_cnt:   DEF_FREQ_CNT,
    amp_h:      DEF_AMP_H,
    amp_l:      DEF_AMP_L,
    polarity:   DEF_POLARITY,
    wait_cnt:   DEF_WAIT_CNT,
    err_offset: DEF_ERR_OFFSET,
    avg_sel:    DEF_AVG_SEL
  };

  // Applies one committed command to the parameter set; unmapped addresses leave it unchanged.
  function automatic cfg_t cfg_write(input cfg_t cur, input logic [7:0] addr,
                                     input logic [31:0] data, input logic [31:0] avg_max);
    cfg_t nxt;
    nxt = cur;
    case (addr)
      ADDR_FREQ:    nxt.freq_cnt   = data;
      ADDR_AMP_H:   nxt.amp_h      = data;
      ADDR_AMP_L:   nxt.amp_l      = data;
      ADDR_POL:     nxt.polarity   = data[0];
      ADDR_WAIT:    nxt.wait_cnt   = data;
      ADDR_ERR_OFS: nxt.err_offset = data;
      ADDR_AVG:     nxt.avg_sel    = (data > avg_max) ? avg_max : data;
      default:      ;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/fog_param_cmd_rx.sv
// Parses 8-byte UART command frames (AB BA ADDR D3..D0 CHK) and drives the
// FOG core loop parameters, with ack pulse, error pulse and saturating error count.
module fog_param_cmd_rx
  import fog_cfg_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 100000,
  parameter logic [31:0] AVG_SEL_MAX = AVG_SEL_MAX_DEF,
  parameter logic [7:0]  HDR0        = 8'hAB,
  parameter logic [7:0]  HDR1        = 8'hBA
) (
  input  logic        pll_clk_cpu_int,
  input  logic        RST_EXT_N,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic [31:0] o_freq_cnt,
  output logic [31:0] o_amp_H,
  output logic [31:0] o_amp_L,
  output logic        o_polarity,
  output logic [31:0] o_wait_cnt,
  output logic [31:0] o_err_offset,
  output logic [31:0] o_avg_sel,
  output logic        o_cfg_update,
  output logic [7:0]  o_cmd_addr,
  output logic        o_err_pulse,
  output logic [7:0]  o_err_cnt
);

  localparam int unsigned       IDLE_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);

  state_e            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [7:0]        addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  cfg_t              cfg_q, cfg_d;
  logic              cfg_update_q, cfg_update_d;
  logic [7:0]        cmd_addr_q, cmd_addr_d;
  logic              err_pulse_q, err_pulse_d;
  logic [7:0]        err_cnt_q, err_cnt_d;

  logic       err_event;
  logic       is_hdr0;
  logic [7:0] chk_exp;

  assign is_hdr0 = i_rx_valid && (i_rx_data == HDR0);
  assign chk_exp = addr_q ^ data_q[31:24] ^ data_q[23:16] ^ data_q[15:8] ^ data_q[7:0];

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d      = state_q;
    idx_d        = idx_q;
    addr_d       = addr_q;
    data_d       = data_q;
    cfg_d        = cfg_q;
    cfg_update_d = 1'b0;
    cmd_addr_d   = cmd_addr_q;
    err_pulse_d  = 1'b0;
    err_cnt_d    = err_cnt_q;
    err_event    = 1'b0;

    if ((state_q == S_HDR0) || (state_q == S_COMMIT) || i_rx_valid) begin
      idle_d = '0;
    end else begin
      idle_d = idle_q + IDLE_W'(1);
    end

    unique case (state_q)
      S_HDR0: begin
        if (is_hdr0) state_d = S_HDR1;
      end
      S_HDR1: begin
        if (i_rx_valid) begin
          if (i_rx_data == HDR1)      state_d = S_ADDR;
          else if (i_rx_data != HDR0) state_d = S_HDR0;
        end
      end
      S_ADDR: begin
        if (i_rx_valid) begin
          addr_d  = i_rx_data;
          idx_d   = 2'd0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (i_rx_valid) begin
          data_d = {data_q[23:0], i_rx_data};
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = S_CHK;
        end
      end
      S_CHK: begin
        if (i_rx_valid) begin
          if ((i_rx_data == chk_exp) && (addr_q <= ADDR_AVG)) begin
            state_d = S_COMMIT;
          end else begin
            err_event = 1'b1;
            state_d   = S_HDR0;
          end
        end
      end
      S_COMMIT: begin
        cfg_d        = cfg_write(cfg_q, addr_q, data_q, AVG_SEL_MAX);
        cfg_update_d = 1'b1;
        cmd_addr_d   = addr_q;
        // A byte landing in the commit cycle may already start the next frame.
        state_d      = is_hdr0 ? S_HDR1 : S_HDR0;
      end
      default: state_d = S_HDR0;
    endcase

    // Abort on the TIMEOUT_CYC-th consecutive idle cycle; a byte in that cycle wins.
    if ((state_q != S_HDR0) && (state_q != S_COMMIT) && !i_rx_valid && (idle_q == IDLE_LAST)) begin
      err_event = 1'b1;
      state_d   = S_HDR0;
      idle_d    = '0;
    end

    if (err_event) begin
      err_pulse_d = 1'b1;
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge pll_clk_cpu_int or negedge RST_EXT_N) begin
    if (!RST_EXT_N) begin
      state_q      <= S_HDR0;
      idx_q        <= 2'd0;
      addr_q       <= 8'd0;
      data_q       <= 32'd0;
      idle_q       <= '0;
      cfg_q        <= CFG_RESET;
      cfg_update_q <= 1'b0;
      cmd_addr_q   <= 8'd0;
      err_pulse_q  <= 1'b0;
      err_cnt_q    <= 8'd0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      idle_q       <= idle_d;
      cfg_q        <= cfg_d;
      cfg_update_q <= cfg_update_d;
      cmd_addr_q   <= cmd_addr_d;
      err_pulse_q  <= err_pulse_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign o_freq_cnt   = cfg_q.freq_cnt;
  assign o_amp_H      = cfg_q.amp_h;
  assign o_amp_L      = cfg_q.amp_l;
  assign o_polarity   = cfg_q.polarity;
  assign o_wait_cnt   = cfg_q.wait_cnt;
  assign o_err_offset = cfg_q.err_offset;
  assign o_avg_sel    = cfg_q.avg_sel;
  assign o_cfg_update = cfg_update_q;
  assign o_cmd_addr   = cmd_addr_q;
  assign o_err_pulse  = err_pulse_q;
  assign o_err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_fog_param_cmd_rx.sv
// Self-checking bench for fog_param_cmd_rx: directed frames from the test plan plus
// randomized frames checked against a frame-level reference model.
module tb_fog_param_cmd_rx;

  localparam int unsigned TMO = 200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [31:0] freq_cnt, amp_h, amp_l, wait_cnt, err_offset, avg_sel;
  logic        polarity, cfg_update, err_pulse;
  logic [7:0]  cmd_addr, err_cnt;

  always #5 clk = ~clk;

  fog_param_cmd_rx #(.TIMEOUT_CYC(TMO)) dut (
    .pll_clk_cpu_int(clk),
    .RST_EXT_N      (rst_n),
    .i_rx_data      (rx_data),
    .i_rx_valid     (rx_valid),
    .o_freq_cnt     (freq_cnt),
    .o_amp_H        (amp_h),
    .o_amp_L        (amp_l),
    .o_polarity     (polarity),
    .o_wait_cnt     (wait_cnt),
    .o_err_offset   (err_offset),
    .o_avg_sel      (avg_sel),
    .o_cfg_update   (cfg_update),
    .o_cmd_addr     (cmd_addr),
    .o_err_pulse    (err_pulse),
    .o_err_cnt      (err_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: parameter values by address, error count, last address, pulse counts.
  logic [31:0] m_cfg [7];
  int          m_err;
  logic [7:0]  m_cmd;
  int          m_upd_pulses;
  int          m_err_pulses;
  int          seen_upd = 0;
  int          seen_err = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (cfg_update) seen_upd++;
      if (err_pulse)  seen_err++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d)", tag, got, got, exp, exp);
  endtask

  task automatic model_reset();
    m_cfg[0] = 1000; m_cfg[1] = 5000; m_cfg[2] = 5000; m_cfg[3] = 0;
    m_cfg[4] = 50;   m_cfg[5] = 0;    m_cfg[6] = 10;
    m_err = 0; m_cmd = 8'h00;
  endtask

  task automatic model_error();
    if (m_err < 255) m_err++;
    m_err_pulses++;
  endtask

  task automatic model_frame(input logic [7:0] addr, input logic [31:0] data, input logic [7:0] chk);
    logic [7:0] good;
    good = addr ^ data[31:24] ^ data[23:16] ^ data[15:8] ^ data[7:0];
    if (chk == good && addr <= 8'd6) begin
      if (addr == 8'd3)      m_cfg[3] = {31'd0, data[0]};
      else if (addr == 8'd6) m_cfg[6] = (data > 32'd14) ? 32'd14 : data;
      else                   m_cfg[addr] = data;
      m_cmd = addr;
      m_upd_pulses++;
    end else begin
      model_error();
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".freq"},   freq_cnt,   m_cfg[0]);
    check({tag, ".amp_h"},  amp_h,      m_cfg[1]);
    check({tag, ".amp_l"},  amp_l,      m_cfg[2]);
    check({tag, ".pol"},    {31'd0, polarity}, m_cfg[3]);
    check({tag, ".wait"},   wait_cnt,   m_cfg[4]);
    check({tag, ".errofs"}, err_offset, m_cfg[5]);
    check({tag, ".avg"},    avg_sel,    m_cfg[6]);
    check({tag, ".errcnt"}, {24'd0, err_cnt}, 32'(m_err));
    check({tag, ".cmd"},    {24'd0, cmd_addr}, {24'd0, m_cmd});
  endtask

  // Called at a negedge; byte is sampled at the following posedge; returns at the next negedge.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] addr, input logic [31:0] data, input logic [7:0] chk,
                            input int max_gap);
    logic [7:0] bytes [8];
    bytes[0] = 8'hAB; bytes[1] = 8'hBA; bytes[2] = addr;
    bytes[3] = data[31:24]; bytes[4] = data[23:16]; bytes[5] = data[15:8]; bytes[6] = data[7:0];
    bytes[7] = chk;
    for (int i = 0; i < 8; i++) begin
      send_byte(bytes[i]);
      if (i < 7 && max_gap > 0) idle($urandom_range(0, max_gap));
    end
    model_frame(addr, data, chk);
  endtask

  initial begin
    logic [7:0]  r_addr, r_chk, r_noise;
    logic [31:0] r_data;
    int          base_err;

    m_upd_pulses = 0;
    m_err_pulses = 0;
    model_reset();
    idle(3);
    rst_n = 1'b1;
    idle(2);
    check_all("reset");
    check("reset.upd", {31'd0, cfg_update}, 32'd0);
    check("reset.errp", {31'd0, err_pulse}, 32'd0);

    // freq_cnt = 2000, exact two-cycle latency after CHK
    send_frame(8'h00, 32'h0000_07D0, 8'hD7, 0);
    check("lat.freq_early", freq_cnt, 32'd1000);
    check("lat.upd_early", {31'd0, cfg_update}, 32'd0);
    idle(1);
    check("lat.freq", freq_cnt, 32'd2000);
    check("lat.upd", {31'd0, cfg_update}, 32'd1);
    check("lat.cmd", {24'd0, cmd_addr}, 32'h00);
    idle(1);
    check("lat.upd_once", {31'd0, cfg_update}, 32'd0);

    // avg_sel clamp
    send_frame(8'h06, 32'h0000_001F, 8'h19, 0);
    idle(2);
    check("clamp.avg", avg_sel, 32'd14);
    check_all("clamp");

    // corrupted checksum
    send_frame(8'h01, 32'h0000_1388, 8'h00, 0);
    check("badchk.errp", {31'd0, err_pulse}, 32'd1);
    idle(1);
    check("badchk.errp_once", {31'd0, err_pulse}, 32'd0);
    check("badchk.errcnt", {24'd0, err_cnt}, 32'd1);
    check_all("badchk");

    // timeout mid-frame, then a good amp_L frame
    base_err = m_err;
    send_byte(8'hAB); send_byte(8'hBA); send_byte(8'h02); send_byte(8'h00);
    idle(TMO - 3);
    check("tmo.early", {24'd0, err_cnt}, 32'(base_err));
    idle(6);
    model_error();
    check("tmo.errcnt", {24'd0, err_cnt}, 32'(m_err));
    send_frame(8'h02, 32'h0000_0064, 8'h66, 0);
    idle(2);
    check("tmo.amp_l", amp_l, 32'd100);
    check_all("tmo");

    // noise and resync, next frame's header byte lands in the commit cycle
    send_byte(8'h12); send_byte(8'hAB);
    send_frame(8'h03, 32'h0000_0001, 8'h02, 0);
    send_frame(8'h04, 32'h0000_000A, 8'h0E, 0);
    idle(2);
    check("noise.pol", {31'd0, polarity}, 32'd1);
    check("noise.wait", wait_cnt, 32'd10);
    check_all("noise");

    // byte arriving in the timeout cycle wins
    send_byte(8'hAB); send_byte(8'hBA); send_byte(8'h05);
    idle(TMO - 1);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h12); send_byte(8'h34); send_byte(8'h23);
    model_frame(8'h05, 32'h0000_1234, 8'h23);
    idle(2);
    check("race.errofs", err_offset, 32'h1234);
    check_all("race");

    // randomized frames
    for (int k = 0; k < 40; k++) begin
      for (int n = $urandom_range(0, 2); n > 0; n--) begin
        r_noise = 8'($urandom_range(0, 255));
        if (r_noise == 8'hAB) r_noise = 8'h11;
        send_byte(r_noise);
      end
      r_addr = 8'($urandom_range(0, 8));
      r_data = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      r_chk  = r_addr ^ r_data[31:24] ^ r_data[23:16] ^ r_data[15:8] ^ r_data[7:0];
      if ($urandom_range(0, 3) == 0) r_chk = r_chk ^ 8'($urandom_range(1, 255));
      send_frame(r_addr, r_data, r_chk, 3);
      idle(2);
      check_all($sformatf("rnd%0d", k));
    end

    check("pulses.upd", 32'(seen_upd), 32'(m_upd_pulses));
    check("pulses.err", 32'(seen_err), 32'(m_err_pulses));

    // error counter saturation
    while (m_err < 255) send_frame(8'h07, 32'h0000_0000, 8'h07, 0);
    idle(1);
    check("sat.at255", {24'd0, err_cnt}, 32'd255);
    send_frame(8'h09, 32'h0000_0000, 8'h09, 0);
    send_frame(8'h01, 32'h0000_0000, 8'h55, 0);
    idle(2);
    check("sat.hold", {24'd0, err_cnt}, 32'd255);
    check_all("sat");

    // reset in the middle of a frame
    send_byte(8'hAB); send_byte(8'hBA); send_byte(8'h00); send_byte(8'h00);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all("midrst");
    idle(2);
    rst_n = 1'b1;
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h12); send_byte(8'h12);
    idle(3);
    check_all("postrst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
